keypad_encoder: RTL and testbench
=================================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clocks each column is driven (min 4).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans to accept a press or a release (min 2).
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port row_in  input  6  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_drive  output  4  keypad columns, active-low one-hot.
REQ-007 SHALL have port keycode  output  5  code of the last accepted key, held until the next accept.
REQ-008 SHALL have port newkey  output  1  one-clock pulse; keycode is valid in that cycle.
REQ-009 SHALL have port key_held  output  1  high while an accepted key has not yet been released.

Function
REQ-010 SHALL pass row_in through a 2-flop synchroniser before any use.
REQ-011 SHALL drive columns in order 0,1,2,3,0,... with exactly one column low, each for SCAN_DIV clocks; a full scan is 4*SCAN_DIV clocks.
REQ-012 SHALL sample the synchronised rows on the last clock of each column dwell.
REQ-013 SHALL classify each full scan at the column-3 sample as NONE (0 keys), SINGLE(k) (exactly 1 key, k=row*4+col) or MULTI (more than 1 key).
REQ-014 SHALL map rows 0-3 to keycode {1'b1, k[3:0]}, i.e. 5'h10+k for k=0..15.
REQ-015 SHALL map row 4, cols 0..3 to 5'h0C (CE), 5'h04 (CA), 5'h02 (change sign), 5'h01 (square).
REQ-016 SHALL map row 5, cols 0..3 to 5'h0B (add), 5'h0A (subtract), 5'h09 (multiply), 5'h03 (equals).
REQ-017 SHALL implement FSM states IDLE, DEBOUNCE, HELD.
REQ-018 IDLE: on SINGLE(k), SHALL store candidate k, set count=1 and go to DEBOUNCE; on NONE or MULTI, SHALL stay in IDLE.
REQ-019 DEBOUNCE: on SINGLE(same k), SHALL increment count; on SINGLE(other k), NONE or MULTI, SHALL return to IDLE without output.
REQ-020 On the scan that brings count to DEBOUNCE_SCANS, SHALL load keycode, pulse newkey for exactly one clock on the following edge, and enter HELD.
REQ-021 HELD: SHALL assert key_held and emit no further newkey (no auto-repeat).
REQ-022 HELD: each NONE scan SHALL increment a release count; any SINGLE or MULTI scan SHALL clear it.
REQ-023 HELD: when the release count reaches DEBOUNCE_SCANS, SHALL return to IDLE and deassert key_held.
REQ-024 SHALL limit newkey to at most one pulse per full scan and never assert it in two consecutive clocks.
REQ-025 SHALL keep the scan counter free-running in every state; FSM decisions occur only at scan boundaries.
REQ-026 A key change in mid-scan SHALL affect only the samples taken after it; no special case is required.

Reset
REQ-027 While rst is high, SHALL hold state=IDLE, col_drive=4'b1110, keycode=5'h00, newkey=0, key_held=0, and clear all counters and synchronisers (rows read as released).
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard the candidate and emit no newkey.
REQ-029 After rst deasserts, scanning SHALL restart at column 0 with a fresh SCAN_DIV dwell.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2, full scan 16 clocks)
REQ-030 Hold row 2/col 1 low -> exactly one newkey pulse with keycode=5'h19; key_held=1 until 2 clean NONE scans after release.
REQ-031 Press row 5/col 3 for 1 scan only, then release -> no newkey; keycode stays 5'h00.
REQ-032 Hold row 0/col 0 and row 4/col 1 together -> no newkey; release one key -> newkey once for the remaining key (5'h10 or 5'h04).
REQ-033 Hold row 4/col 3 for 20 scans -> exactly one newkey with keycode=5'h01 and no repeat.
REQ-034 Assert rst one scan into DEBOUNCE on row 5/col 0 -> outputs return to reset values and no 5'h0B pulse appears; after release of rst with the key still held, the press is accepted normally.
REQ-035 Sweep all 24 keys -> each key produces the keycode in REQ-014..016 exactly once, and col_drive is always one-hot low.

Source files
------------

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 6x4 keypad scanner with debounced single-key encoding
// Columns are scanned one-hot low; each full scan is classified and debounced.
module keypad_encoder #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] row_in,
  output logic [3:0] col_drive,
  output logic [4:0] keycode,
  output logic       newkey,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;

  logic [5:0]    row_s1, row_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col;
  logic [1:0]    acc_cnt;
  logic [4:0]    acc_k;
  logic [1:0]    state;
  logic [4:0]    cand_k;
  logic [CW-1:0] cnt;

  logic          sample, scan_end;
  logic [5:0]    pressed;
  logic [2:0]    col_cnt, col_row;
  logic [1:0]    base_cnt, scan_cnt;
  logic [3:0]    sum_cnt;
  logic [4:0]    scan_k;

  assign sample    = (div_cnt == DW'(SCAN_DIV - 1));
  assign scan_end  = sample && (col == 2'd3);
  assign col_drive = ~(4'b0001 << col);
  assign key_held  = (state == S_HELD);

  // Per-column key count (saturating at 2 across the scan) and index of a lone key.
  always_comb begin
    pressed = ~row_s2;
    col_cnt = 3'd0;
    col_row = 3'd0;
    for (int r = 5; r >= 0; r--) begin
      if (pressed[r]) col_row = 3'(r);
      col_cnt = col_cnt + {2'b00, pressed[r]};
    end
    base_cnt = (col == 2'd0) ? 2'd0 : acc_cnt;
    sum_cnt  = {2'b00, base_cnt} + {1'b0, col_cnt};
    scan_cnt = (sum_cnt > 4'd1) ? 2'd2 : sum_cnt[1:0];
    if (col_cnt == 3'd1)
      scan_k = {col_row, col};
    else if (col == 2'd0)
      scan_k = 5'd0;
    else
      scan_k = acc_k;
  end

  function automatic logic [4:0] key_map(input logic [4:0] k);
    logic [4:0] code;
    if (k < 5'd16)
      code = {1'b1, k[3:0]};
    else if (k[4:2] == 3'd4) begin
      case (k[1:0])
        2'd0:    code = 5'h0C;
        2'd1:    code = 5'h04;
        2'd2:    code = 5'h02;
        default: code = 5'h01;
      endcase
    end else begin
      case (k[1:0])
        2'd0:    code = 5'h0B;
        2'd1:    code = 5'h0A;
        2'd2:    code = 5'h09;
        default: code = 5'h03;
      endcase
    end
    return code;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1  <= 6'h3F;
      row_s2  <= 6'h3F;
      div_cnt <= '0;
      col     <= 2'd0;
      acc_cnt <= 2'd0;
      acc_k   <= 5'd0;
      state   <= S_IDLE;
      cand_k  <= 5'd0;
      cnt     <= '0;
      keycode <= 5'h00;
      newkey  <= 1'b0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      newkey <= 1'b0;
      if (sample) begin
        div_cnt <= '0;
        col     <= col + 2'd1;
        acc_cnt <= scan_cnt;
        acc_k   <= scan_k;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (scan_end) begin
        case (state)
          S_IDLE: begin
            if (scan_cnt == 2'd1) begin
              cand_k <= scan_k;
              cnt    <= CW'(1);
              state  <= S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (scan_cnt == 2'd1 && scan_k == cand_k) begin
              if (cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
                keycode <= key_map(cand_k);
                newkey  <= 1'b1;
                cnt     <= '0;
                state   <= S_HELD;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          S_HELD: begin
            // Any activity during hold restarts the release debounce.
            if (scan_cnt == 2'd0) begin
              if (cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
                cnt   <= '0;
                state <= S_IDLE;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              cnt <= '0;
            end
          end
          default: begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - randomized scan-level model check of keypad_encoder
// Keys change only at scan boundaries; the model works on whole-scan key sets.
module tb_keypad_encoder;
  localparam int SD = 4;
  localparam int DB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] row_in;
  logic [3:0] col_drive;
  logic [4:0] keycode;
  logic       newkey;
  logic       key_held;
  logic [23:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int nk_count = 0;

  logic [4:0] code_tab [24];
  logic [4:0] exp_keycode;
  logic       exp_newkey, exp_held;
  int         run_k, run_len, rel_len;

  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_drive(col_drive),
    .keycode(keycode), .newkey(newkey), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row_in = 6'h3F;
    for (int r = 0; r < 6; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_drive);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_keycode = 5'h00;
    exp_newkey  = 1'b0;
    exp_held    = 1'b0;
    run_k = 0; run_len = 0; rel_len = 0;
  endtask

  task automatic model_scan(input logic [23:0] ks);
    int n, k;
    n = $countones(ks);
    k = 0;
    for (int i = 0; i < 24; i++) if (ks[i]) k = i;
    if (!exp_held) begin
      if (n == 1) begin
        if (run_len == 0) begin run_k = k; run_len = 1; end
        else if (k == run_k) run_len++;
        else run_len = 0;
        if (run_len == DB) begin
          exp_held = 1'b1; exp_newkey = 1'b1; exp_keycode = code_tab[k];
          run_len = 0; rel_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end else if (n == 0) begin
      rel_len++;
      if (rel_len == DB) begin exp_held = 1'b0; rel_len = 0; end
    end else begin
      rel_len = 0;
    end
  endtask

  task automatic run_scan(input logic [23:0] ks);
    logic [3:0] ec;
    keys = ks;
    for (int j = 1; j <= 4 * SD; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 4 * SD) model_scan(ks);
      else exp_newkey = 1'b0;
      ec = ~(4'b0001 << ((j / SD) % 4));
      if (newkey) nk_count++;
      check("newkey", newkey, exp_newkey);
      check("keycode", keycode, exp_keycode);
      check("key_held", key_held, exp_held);
      check("col_drive", col_drive, ec);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_col", col_drive, 4'b1110);
      check("rst_keycode", keycode, 5'h00);
      check("rst_newkey", newkey, 1'b0);
      check("rst_held", key_held, 1'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_n(input logic [23:0] ks, input int n);
    for (int i = 0; i < n; i++) run_scan(ks);
  endtask

  initial begin
    int base;
    logic [23:0] cur;
    for (int i = 0; i < 16; i++) code_tab[i] = 5'(16 + i);
    code_tab[16] = 5'h0C; code_tab[17] = 5'h04; code_tab[18] = 5'h02; code_tab[19] = 5'h01;
    code_tab[20] = 5'h0B; code_tab[21] = 5'h0A; code_tab[22] = 5'h09; code_tab[23] = 5'h03;
    model_reset();
    @(negedge clk);
    do_reset();

    // Short press on row 5 col 3 is rejected.
    base = nk_count;
    run_n(24'd1 << 23, 1);
    run_n(24'd0, 3);
    check("short_press_pulses", nk_count - base, 0);
    check("short_press_keycode", keycode, 5'h00);

    // Row 2 col 1 held, then released over two clean scans.
    base = nk_count;
    run_n(24'd1 << 9, 3);
    check("held_after_press", key_held, 1'b1);
    run_n(24'd0, 1);
    check("held_one_none", key_held, 1'b1);
    run_n(24'd0, 1);
    check("held_released", key_held, 1'b0);
    check("r2c1_pulses", nk_count - base, 1);
    check("r2c1_keycode", keycode, 5'h19);

    // Two keys together, then one released.
    base = nk_count;
    run_n((24'd1 << 0) | (24'd1 << 17), 4);
    check("multi_pulses", nk_count - base, 0);
    run_n(24'd1 << 17, 3);
    check("remaining_pulses", nk_count - base, 1);
    check("remaining_keycode", keycode, 5'h04);
    run_n(24'd0, 3);

    // Long hold: no auto-repeat.
    base = nk_count;
    run_n(24'd1 << 19, 20);
    check("long_hold_pulses", nk_count - base, 1);
    check("long_hold_keycode", keycode, 5'h01);
    run_n(24'd0, 3);

    // Reset one scan into debounce, key stays down through and after reset.
    base = nk_count;
    run_n(24'd1 << 20, 1);
    do_reset();
    check("reset_no_pulse", nk_count - base, 0);
    run_n(24'd1 << 20, 3);
    check("after_reset_pulses", nk_count - base, 1);
    check("after_reset_keycode", keycode, 5'h0B);
    run_n(24'd0, 3);

    // Sweep all keys.
    base = nk_count;
    for (int k = 0; k < 24; k++) begin
      run_n(24'd1 << k, 3);
      check("sweep_keycode", keycode, code_tab[k]);
      run_n(24'd0, 3);
    end
    check("sweep_pulses", nk_count - base, 24);

    // Random key activity at scan granularity.
    cur = '0;
    for (int s = 0; s < 150; s++) begin
      int mode;
      mode = int'($urandom_range(0, 9));
      if (mode >= 4 && mode <= 5) cur = '0;
      else if (mode >= 6 && mode <= 8) cur = 24'd1 << $urandom_range(0, 23);
      else if (mode == 9) cur = (24'd1 << $urandom_range(0, 23)) | (24'd1 << $urandom_range(0, 23));
      run_scan(cur);
    end
    run_n(24'd0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
